moore_pattern_detector: RTL and testbench
=========================================

// Module: moore_pattern_detector
// PURPOSE
//  - Parametrised Moore-type serial pattern detector. It is the next-generation
//    form of the team's regular Moore FSM template.
//  - Pattern width and value, overlap mode and counter width are set by
//    parameters. States are derived from the pattern, not hand-listed.
//  - Sits behind any 1-bit serial stream that has a qualifier (sample enable).
//  - Outputs: a Moore "detected" flag and a saturating match counter, both for
//    control and status logic.
// PARAMETERS
//  - PAT_W    4        pattern length in bits, >= 2
//  - PATTERN  4'b1011  pattern bits, PAT_W wide; MSB is the first bit received
//  - OVERLAP  1        1: matches may overlap; 0: restart after each match
//  - CNT_W    8        width of match_count, >= 1
// PORTS
//  - clk          in   1      single clock, rising edge
//  - reset        in   1      asynchronous, active-high
//  - en           in   1      sample qualifier; din is consumed only when en=1
//  - din          in   1      serial data bit
//  - clear        in   1      synchronous clear of match_count
//  - detected     out  1      Moore output, high while the state is S_FOUND
//  - match_count  out  CNT_W  number of detections, saturating
//  - busy         out  1      high when the state is neither S_IDLE nor S_FOUND
// BEHAVIOUR
//  - State encoding
//    - state_reg = number of pattern bits currently matched, 0..PAT_W.
//    - Width is $clog2(PAT_W+1).
//    - 0 = S_IDLE, 1..PAT_W-1 = S_Mk, PAT_W = S_FOUND.
//  - Reset (asynchronous, active-high)
//    - state_reg = S_IDLE, detected = 0, busy = 0, match_count = 0.
//  - en = 0: state_reg and match_count hold; din is ignored.
//    - clear still acts when en = 0.
//  - en = 1 in S_IDLE or S_Mk (k matched bits)
//    - If din == PATTERN[PAT_W-1-k], next state = k+1.
//    - Otherwise, next state = the longest prefix of PATTERN that is a suffix of
//      (matched prefix followed by din). This is the KMP failure rule.
//    - The failure table is computed at elaboration with a constant function.
//      No runtime search.
//  - en = 1 in S_FOUND
//    - OVERLAP = 1: apply the failure rule from state PAT_W.
//    - OVERLAP = 0: treat the state as S_IDLE, then apply din.
//      Next state is 1 if din == PATTERN[PAT_W-1], else 0.
//  - detected
//    - Rises in the cycle after the edge that samples the last pattern bit.
//    - Stays high for as long as the state remains S_FOUND, including en = 0
//      gaps.
//  - match_count
//    - Increments by 1 on each edge where next state = S_FOUND and en = 1.
//    - Saturates at 2^CNT_W - 1 and does not wrap.
//    - clear = 1 forces 0 on that edge. clear wins over a simultaneous increment.
//    - clear has no effect on state_reg.
//  - Reset mid-pattern discards any partial match. A full pattern is required
//    after reset is released.
// CONFIGURATION
//  - MOORE_REG_OUT_EN defined
//    - detected and busy come from D-FFs fed by the decoded next-cycle value.
//    - Outputs are glitch-free with the same latency as the undefined case.
//    - Register reset value is 0.
//  - MOORE_REG_OUT_EN undefined
//    - detected and busy are decoded combinationally from state_reg.
//  - match_count is always registered in both builds.
// TESTING (defaults unless stated; run each with and without MOORE_REG_OUT_EN)
//  - Reset: assert reset asynchronously mid-cycle.
//    -> detected = 0, busy = 0, match_count = 0 immediately.
//  - Basic match: en = 1, din = 1,0,1,1.
//    -> detected = 1 in the cycle after the 4th edge; match_count = 1.
//  - Overlap on: din = 1,0,1,1,0,1,1.
//    -> detected pulses twice; match_count = 2.
//  - Overlap off (OVERLAP = 0): same stream.
//    -> one detection; match_count = 1.
//  - en gaps: din = 1,0, then en = 0 for 5 cycles with din toggling, then 1,1.
//    -> one detection.
//    - busy stays high through the gap.
//    - detected holds while en = 0 after the match.
//  - Saturate and clear (CNT_W = 2): 5 detections.
//    -> match_count = 3.
//    - Then clear = 1 on the edge of a 6th detection.
//    -> match_count = 0 and detected = 1.
//  - Reset mid-pattern: din = 1,0,1, assert reset, then din = 1.
//    -> no detection; the full 1,0,1,1 is needed to detect.

Source files
------------

// File: rtl/moore_pattern_detector_if.sv
// Serial sample bus for moore_pattern_detector.
//   en, din, clear        : producer -> detector (sample qualifier, data bit, counter clear)
//   detected, busy        : detector -> consumer (Moore status flags)
//   match_count [CNT_W]   : detector -> consumer (saturating detection count)
// The producer side uses modport master; the detector uses modport slave.
interface moore_pattern_detector_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic             din;
   logic             clear;
   logic             detected;
   logic             busy;
   logic [CNT_W-1:0] match_count;

   modport master (output en, din, clear, input detected, busy, match_count);
   modport slave  (input en, din, clear, output detected, busy, match_count);
endinterface

// File: rtl/moore_pattern_detector.sv
// Parametrised Moore serial pattern detector.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : moore_pattern_detector_if.slave
//            en/din/clear in, detected/busy/match_count out
// The state is the number of pattern bits currently matched (0 = S_IDLE,
// PAT_W = S_FOUND). Mismatches follow a KMP-style transition table that is
// built at elaboration from PATTERN, so no search happens at run time.
// Build option: define MOORE_REG_OUT_EN to register detected/busy from the
// decoded next state (same latency, glitch-free); otherwise they are decoded
// combinationally from the state register.
module moore_pattern_detector #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   moore_pattern_detector_if.slave bus
);
   localparam int SW = $clog2(PAT_W + 1);

   typedef enum logic [SW-1:0] {
      S_IDLE  = '0,
      S_FOUND = PAT_W[SW-1:0]
   } state_t;

   // Next state from k matched bits when bit b arrives: the longest prefix of
   // PATTERN that is a suffix of (first k pattern bits, then b).
   function automatic logic [SW-1:0] next_of(input int k, input logic b);
      logic [PAT_W:0] s;      // s[i] = i-th bit of the string, oldest first
      logic [SW-1:0]  res;
      logic           done;
      logic           ok;
      int             len;
      s    = '0;
      res  = '0;
      done = 1'b0;
      for (int i = 0; i < PAT_W; i++)
         if (i < k) s[i] = PATTERN[PAT_W-1-i];
      s[k] = b;
      len  = k + 1;
      for (int j = PAT_W; j >= 1; j--) begin
         if (!done && j <= len) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++)
               if (s[len-j+i] != PATTERN[PAT_W-1-i]) ok = 1'b0;
            if (ok) begin
               res  = SW'(j);
               done = 1'b1;
            end
         end
      end
      return res;
   endfunction

   state_t tab [0:PAT_W][0:1];

   for (genvar g = 0; g <= PAT_W; g++) begin : g_tab
      localparam logic [SW-1:0] N0 = next_of(g, 1'b0);
      localparam logic [SW-1:0] N1 = next_of(g, 1'b1);
      assign tab[g][0] = state_t'(N0);
      assign tab[g][1] = state_t'(N1);
   end

   state_t           state_reg, state_nxt;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_nxt;
   end

   always_comb begin
      state_nxt = state_reg;
      if (bus.en) begin
         // Without overlap a completed match restarts from scratch.
         if (!OVERLAP && state_reg == S_FOUND) state_nxt = tab[0][bus.din];
         else                                 state_nxt = tab[state_reg][bus.din];
      end
   end

   // clear wins over an increment; count sticks at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (bus.clear)
         cnt <= '0;
      else if (bus.en && state_nxt == S_FOUND && cnt != '1)
         cnt <= cnt + 1'b1;
   end

   assign bus.match_count = cnt;

`ifdef MOORE_REG_OUT_EN
   logic det_q, busy_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         det_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         det_q  <= (state_nxt == S_FOUND);
         busy_q <= (state_nxt != S_IDLE) && (state_nxt != S_FOUND);
      end
   end

   assign bus.detected = det_q;
   assign bus.busy     = busy_q;
`else
   assign bus.detected = (state_reg == S_FOUND);
   assign bus.busy     = (state_reg != S_IDLE) && (state_reg != S_FOUND);
`endif

endmodule

// File: tb/tb_moore_pattern_detector.sv
// Bench for moore_pattern_detector: three instances share one stimulus stream
//   u0: defaults (OVERLAP=1, CNT_W=8), u1: OVERLAP=0, u2: CNT_W=2.
// A history-based reference model pushes expected outputs per edge; they are
// popped and compared one time unit after the edge.
module tb_moore_pattern_detector;
   localparam int ND    = 3;
   localparam int PAT_W = 4;

   typedef struct {
      logic       det;
      logic       busy;
      logic [7:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset, en, din, clear;
   int   checks = 0;
   int   errors = 0;

   exp_t sb[$];

   logic       det_o  [ND];
   logic       busy_o [ND];
   logic [7:0] cnt_o  [ND];

   // reference model state, per instance
   logic [PAT_W-1:0] m_hist  [ND];
   int               m_n     [ND];
   int               m_len   [ND];
   int               m_cnt   [ND];
   logic             m_found [ND];
   logic             m_ovl   [ND];
   int               m_cmax  [ND];

   always #5 clk = ~clk;

   moore_pattern_detector_if #(.CNT_W(8)) if0 ();
   moore_pattern_detector_if #(.CNT_W(8)) if1 ();
   moore_pattern_detector_if #(.CNT_W(2)) if2 ();

   moore_pattern_detector u0 (.clk(clk), .reset(reset), .bus(if0));
   moore_pattern_detector #(.OVERLAP(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1));
   moore_pattern_detector #(.CNT_W(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

   assign if0.en = en;  assign if0.din = din;  assign if0.clear = clear;
   assign if1.en = en;  assign if1.din = din;  assign if1.clear = clear;
   assign if2.en = en;  assign if2.din = din;  assign if2.clear = clear;

   assign det_o[0] = if0.detected;  assign busy_o[0] = if0.busy;  assign cnt_o[0] = if0.match_count;
   assign det_o[1] = if1.detected;  assign busy_o[1] = if1.busy;  assign cnt_o[1] = if1.match_count;
   assign det_o[2] = if2.detected;  assign busy_o[2] = if2.busy;  assign cnt_o[2] = {6'd0, if2.match_count};

   task automatic model_reset();
      for (int i = 0; i < ND; i++) begin
         m_hist[i]  = '0;
         m_n[i]     = 0;
         m_len[i]   = 0;
         m_cnt[i]   = 0;
         m_found[i] = 1'b0;
      end
   endtask

   // Longest pattern prefix ending the stream of consumed bits (brute force).
   task automatic model_edge(input logic e, input logic d, input logic c);
      logic [PAT_W-1:0] pat;
      logic             ok;
      exp_t             x;
      pat = 4'b1011;
      for (int i = 0; i < ND; i++) begin
         if (e) begin
            if (m_found[i] && !m_ovl[i]) m_n[i] = 0;
            m_hist[i] = {m_hist[i][PAT_W-2:0], d};
            if (m_n[i] < PAT_W) m_n[i]++;
            m_len[i] = 0;
            for (int j = 1; j <= PAT_W; j++) begin
               if (j <= m_n[i]) begin
                  ok = 1'b1;
                  for (int b = 0; b < j; b++)
                     if (m_hist[i][j-1-b] != pat[PAT_W-1-b]) ok = 1'b0;
                  if (ok) m_len[i] = j;
               end
            end
            m_found[i] = (m_len[i] == PAT_W);
         end
         if (c) m_cnt[i] = 0;
         else if (e && m_found[i] && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
         x.det  = m_found[i];
         x.busy = (m_len[i] > 0) && (m_len[i] < PAT_W);
         x.cnt  = 8'(m_cnt[i]);
         sb.push_back(x);
      end
   endtask

   // One clock edge: drive, let the model predict, then score all instances.
   task automatic cyc(input logic e, input logic d, input logic c);
      exp_t x;
      en = e; din = d; clear = c;
      @(posedge clk);
      model_edge(e, d, c);
      #1;
      for (int i = 0; i < ND; i++) begin
         x = sb.pop_front();
         checks++;
         if (det_o[i] !== x.det || busy_o[i] !== x.busy || cnt_o[i] !== x.cnt) begin
            errors++;
            $display("FAIL sb u%0d t=%0t got det=%b busy=%b cnt=%0d exp det=%b busy=%b cnt=%0d",
                     i, $time, det_o[i], busy_o[i], cnt_o[i], x.det, x.busy, x.cnt);
         end
      end
   endtask

   task automatic send_1011();
      cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
   endtask

   // Asynchronous reset asserted mid-cycle, released on a falling edge.
   task automatic do_reset();
      en = 0; din = 0; clear = 0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < ND; i++) begin
         checks++;
         if (det_o[i] !== 1'b0 || busy_o[i] !== 1'b0 || cnt_o[i] !== 8'd0) begin
            errors++;
            $display("FAIL reset_async u%0d got det=%b busy=%b cnt=%0d exp 0/0/0",
                     i, det_o[i], busy_o[i], cnt_o[i]);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      send_1011();
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      send_1011();
      checks++;
      if (det_o[0] !== 1'b1 || cnt_o[0] !== 8'd1) begin
         errors++;
         $display("FAIL basic got det=%b cnt=%0d exp det=1 cnt=1", det_o[0], cnt_o[0]);
      end
   endtask

   task automatic test_overlap();
      do_reset();
      send_1011();
      cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
      checks++;
      if (cnt_o[0] !== 8'd2 || det_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL overlap_on got cnt=%0d det=%b exp cnt=2 det=1", cnt_o[0], det_o[0]);
      end
      checks++;
      if (cnt_o[1] !== 8'd1 || det_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL overlap_off got cnt=%0d det=%b exp cnt=1 det=0", cnt_o[1], det_o[1]);
      end
   endtask

   task automatic test_en_gaps();
      do_reset();
      cyc(1, 1, 0); cyc(1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc(0, k[0], 0);
         checks++;
         if (busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL gap_busy got %b exp 1", busy_o[0]);
         end
      end
      cyc(1, 1, 0); cyc(1, 1, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(0, ~k[0], 0);
         checks++;
         if (det_o[0] !== 1'b1 || cnt_o[0] !== 8'd1) begin
            errors++;
            $display("FAIL gap_hold got det=%b cnt=%0d exp det=1 cnt=1", det_o[0], cnt_o[0]);
         end
      end
   endtask

   task automatic test_saturate_clear();
      do_reset();
      for (int k = 0; k < 5; k++) send_1011();
      checks++;
      if (cnt_o[2] !== 8'd3) begin
         errors++;
         $display("FAIL saturate got %0d exp 3", cnt_o[2]);
      end
      cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 1);
      checks++;
      if (cnt_o[2] !== 8'd0 || det_o[2] !== 1'b1) begin
         errors++;
         $display("FAIL clear_wins got cnt=%0d det=%b exp cnt=0 det=1", cnt_o[2], det_o[2]);
      end
      // clear while en is low still acts and leaves the state alone
      cyc(1, 1, 0);
      cyc(0, 0, 1);
      checks++;
      if (cnt_o[0] !== 8'd0 || busy_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL clear_idle got cnt=%0d busy=%b exp cnt=0 busy=1", cnt_o[0], busy_o[0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0);
      do_reset();
      cyc(1, 1, 0);
      checks++;
      if (det_o[0] !== 1'b0 || busy_o[0] !== 1'b1 || cnt_o[0] !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid got det=%b busy=%b cnt=%0d exp det=0 busy=1 cnt=0",
                  det_o[0], busy_o[0], cnt_o[0]);
      end
      cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
      checks++;
      if (det_o[0] !== 1'b1 || cnt_o[0] !== 8'd1) begin
         errors++;
         $display("FAIL reset_mid_full got det=%b cnt=%0d exp det=1 cnt=1", det_o[0], cnt_o[0]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 200; k++)
         cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 31) == 0));
   endtask

   initial begin
      m_ovl[0] = 1'b1; m_cmax[0] = 255;
      m_ovl[1] = 1'b0; m_cmax[1] = 255;
      m_ovl[2] = 1'b1; m_cmax[2] = 3;
      model_reset();
      reset = 1'b1; en = 0; din = 0; clear = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_basic();
      test_overlap();
      test_en_gaps();
      test_saturate_clear();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
